odometer_meas_seq: RTL and testbench
====================================

Name: odometer_meas_seq

Overview:
Measurement sequencer for the odometer ring-oscillator aging sensor. It sits directly upstream of the power/ROSC enable stage and drives that stage's MEAS_STRESS and MEAS_DONE controls. It runs a settle period, then a fixed gate window in which it counts synchronized beat pulses from the stressed/reference ROSC beat detector. It latches the count as the aging result.

Parameters:
CNT_W, 16, width of beat counter and RESULT
WIN_W, 16, width of WINDOW_CYCLES configuration input
SETTLE_CYCLES, 8, cycles ROSCs run before counting starts (>=1)

Ports:
CLK  input  1  block clock
RESET  input  1  reset, synchronous, active-high
MEAS_REQ  input  1  request pulse; sampled only in IDLE
ABORT  input  1  terminate a measurement in progress, no result
WINDOW_CYCLES  input  WIN_W  gate window length in CLK cycles; sampled at MEAS_REQ acceptance
BEAT_IN  input  1  beat pulse, already synchronized to CLK, one cycle per beat
MEAS_STRESS  output  1  measurement active; drives ROSC enable stage
MEAS_DONE  output  1  sticky completion flag; gates ROSC off in enable stage
BUSY  output  1  sequencer not in IDLE
RESULT  output  CNT_W  beat count of last completed window
RESULT_VALID  output  1  one-cycle pulse when RESULT updates
OVERFLOW  output  1  last completed window saturated the counter
VDD, VSS  input  1  supply pins, no logical function

Behaviour:
- Single clock CLK. Reset is synchronous, active-high, named RESET. All state updates on CLK rising edge.
- Reset values: state IDLE; MEAS_STRESS=0, MEAS_DONE=0, BUSY=0, RESULT=0, RESULT_VALID=0, OVERFLOW=0; internal counters=0.
- States: IDLE, SETTLE, MEASURE, DONE.
- IDLE: MEAS_REQ=1 -> SETTLE. On acceptance:
  - latch WINDOW_CYCLES, with 0 treated as 1;
  - clear MEAS_DONE and the beat counter;
  - load settle counter.
- SETTLE: stays exactly SETTLE_CYCLES cycles, then -> MEASURE. BEAT_IN is ignored.
- MEASURE: stays exactly latched-window cycles, then -> DONE.
  - Each cycle with BEAT_IN=1 increments the beat counter.
  - The counter saturates at all-ones and sets an internal overflow bit. It does not wrap.
- DONE: lasts one cycle, then -> IDLE.
  - RESULT <= beat counter; OVERFLOW <= overflow bit; RESULT_VALID=1 for this cycle only.
  - MEAS_DONE set to 1 and held until the next accepted MEAS_REQ or RESET.
- MEAS_STRESS is registered: 1 in SETTLE, MEASURE and DONE; 0 in IDLE. Because MEAS_DONE=1 during DONE, the downstream ROSC enable drops while stress power is still on.
- BUSY=1 in every state except IDLE.
- Latency: MEAS_REQ sampled at edge k -> MEAS_STRESS=1 from cycle k+1. First counted cycle is k+1+SETTLE_CYCLES. RESULT_VALID occurs at cycle k+1+SETTLE_CYCLES+window.
- MEAS_REQ outside IDLE is ignored; it is not queued.
- ABORT=1 in SETTLE/MEASURE/DONE -> IDLE next cycle.
  - MEAS_STRESS drops.
  - RESULT, OVERFLOW and MEAS_DONE are unchanged; no RESULT_VALID pulse.
  - ABORT takes priority over state completion in the same cycle.
  - ABORT in IDLE has no effect; MEAS_REQ and ABORT together in IDLE -> request ignored.
- A BEAT_IN in the final MEASURE cycle is counted. A BEAT_IN in the DONE cycle is not.
- RESET mid-operation returns everything to reset values, including RESULT.

Decomposition:
- Shared package odometer_pkg: state enum encoding (IDLE=2'd0, SETTLE=2'd1, MEASURE=2'd2, DONE=2'd3) and default CNT_W/WIN_W constants, for reuse by the stress timer and readout blocks.
- One sub-module, odometer_sat_counter: CNT_W-bit saturating up-counter with synchronous clear, enable and overflow flag. Instantiated for the beat count.
- Settle and window down-counters stay inline.

Test Plan:
- SETTLE_CYCLES=4, WINDOW_CYCLES=10, MEAS_REQ at cycle 0, BEAT_IN=1 on alternate cycles throughout -> MEAS_STRESS high cycles 1-15; RESULT_VALID at cycle 15 with RESULT=5, OVERFLOW=0; MEAS_DONE high from 15; BUSY low at 16.
- CNT_W=4, WINDOW_CYCLES=20, BEAT_IN constantly 1 -> RESULT=15, OVERFLOW=1; a following run with no beats -> RESULT=0, OVERFLOW=0.
- WINDOW_CYCLES=0 -> exactly one MEASURE cycle; BEAT_IN=1 in that cycle -> RESULT=1.
- ABORT during MEASURE after prior result 5 -> IDLE next cycle, MEAS_STRESS=0, RESULT still 5, no RESULT_VALID, MEAS_DONE stays 0.
- MEAS_REQ pulses during SETTLE and MEASURE -> ignored; exactly one RESULT_VALID; a new MEAS_REQ in IDLE clears MEAS_DONE the next cycle.
- RESET asserted in MEASURE -> all outputs 0 next cycle; BEAT_IN in the DONE cycle is never counted (check RESULT against beats placed at the window boundaries).

Source files
------------

// File: rtl/odometer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : odometer_pkg
// Purpose  : Shared sequencer state encoding and default widths for the
//            odometer aging-sensor blocks.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package odometer_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } meas_state_t;

endpackage
`default_nettype wire

// File: rtl/odometer_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : odometer_sat_counter
// Purpose  : Saturating up-counter with synchronous clear and sticky overflow;
//            also exposes the value it will hold after the coming edge.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module odometer_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_count_nxt,
  output logic             o_overflow_nxt
);

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_overflow_nxt;

  // An increment attempted at all-ones holds the count and flags overflow.
  always_comb begin
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    if (i_clear) begin
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end else if (i_en) begin
      if (&r_count) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + c_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_count_nxt    = w_count_nxt;
  assign o_overflow_nxt = w_overflow_nxt;

endmodule
`default_nettype wire

// File: rtl/odometer_meas_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : odometer_meas_seq
// Purpose  : Odometer measurement sequencer: settle, gated beat count, latch.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module odometer_meas_seq
  import odometer_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int WIN_W         = WIN_W_DEF,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             MEAS_REQ,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW_CYCLES,
  input  logic             BEAT_IN,
  output logic             MEAS_STRESS,
  output logic             MEAS_DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] RESULT,
  output logic             RESULT_VALID,
  output logic             OVERFLOW,
  input  logic             VDD,
  input  logic             VSS
);

  localparam int                 c_SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_SET_W-1:0] c_SETTLE_LOAD = c_SET_W'(SETTLE_CYCLES - 1);
  localparam logic [c_SET_W-1:0] c_SET_ONE     = {{(c_SET_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0]   c_WIN_ONE     = {{(WIN_W-1){1'b0}}, 1'b1};

  meas_state_t        r_state;
  meas_state_t        w_state_nxt;
  logic [c_SET_W-1:0] r_settle_cnt;
  logic [WIN_W-1:0]   r_win_cnt;
  logic               w_accept;
  logic               w_finish;

  logic               r_stress;
  logic               r_meas_done;
  logic [CNT_W-1:0]   r_result;
  logic               r_result_valid;
  logic               r_overflow;

  logic [CNT_W-1:0]   w_cnt_q;
  logic               w_ovf_q;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ovf_nxt;
  logic               w_unused;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ABORT outranks completion; a request alongside ABORT in IDLE is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (MEAS_REQ && !ABORT) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else if (r_settle_cnt == '0) begin
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (ABORT) begin
          w_state_nxt = ST_IDLE;
        end else if (r_win_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Both counters hold (remaining cycles - 1); a zero window runs one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
    end else if (w_accept) begin
      r_settle_cnt <= c_SETTLE_LOAD;
      r_win_cnt    <= (WINDOW_CYCLES == '0) ? '0 : (WINDOW_CYCLES - c_WIN_ONE);
    end else begin
      if ((r_state == ST_SETTLE) && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - c_SET_ONE;
      end
      if ((r_state == ST_MEASURE) && (r_win_cnt != '0)) begin
        r_win_cnt <= r_win_cnt - c_WIN_ONE;
      end
    end
  end

  odometer_sat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clk            (CLK),
    .rst            (RESET),
    .i_clear        (w_accept),
    .i_en           ((r_state == ST_MEASURE) && BEAT_IN),
    .o_count        (w_cnt_q),
    .o_overflow     (w_ovf_q),
    .o_count_nxt    (w_cnt_nxt),
    .o_overflow_nxt (w_ovf_nxt)
  );

  // The result is taken from the counter's next value so a beat in the last
  // MEASURE cycle is included while RESULT and RESULT_VALID align with DONE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stress       <= 1'b0;
      r_meas_done    <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_stress       <= (w_state_nxt != ST_IDLE);
      r_result_valid <= w_finish;
      if (w_accept) begin
        r_meas_done <= 1'b0;
      end else if (w_finish) begin
        r_meas_done <= 1'b1;
      end
      if (w_finish) begin
        r_result   <= w_cnt_nxt;
        r_overflow <= w_ovf_nxt;
      end
    end
  end

  assign MEAS_STRESS  = r_stress;
  assign MEAS_DONE    = r_meas_done;
  assign BUSY         = (r_state != ST_IDLE);
  assign RESULT       = r_result;
  assign RESULT_VALID = r_result_valid;
  assign OVERFLOW     = r_overflow;

  assign w_unused = ^{VDD, VSS, w_cnt_q, w_ovf_q};

endmodule
`default_nettype wire

// File: tb/tb_odometer_meas_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_odometer_meas_seq
// Purpose  : Scoreboard bench for odometer_meas_seq (CNT_W=4, SETTLE=4).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_odometer_meas_seq;

  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int S     = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             MEAS_REQ;
  logic             ABORT;
  logic [WIN_W-1:0] WINDOW_CYCLES;
  logic             BEAT_IN;
  logic             MEAS_STRESS;
  logic             MEAS_DONE;
  logic             BUSY;
  logic [CNT_W-1:0] RESULT;
  logic             RESULT_VALID;
  logic             OVERFLOW;
  logic             VDD = 1'b1;
  logic             VSS = 1'b0;

  typedef struct packed {
    logic [CNT_W-1:0] res;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  odometer_meas_seq #(
    .CNT_W         (CNT_W),
    .WIN_W         (WIN_W),
    .SETTLE_CYCLES (S)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .MEAS_REQ      (MEAS_REQ),
    .ABORT         (ABORT),
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .BEAT_IN       (BEAT_IN),
    .MEAS_STRESS   (MEAS_STRESS),
    .MEAS_DONE     (MEAS_DONE),
    .BUSY          (BUSY),
    .RESULT        (RESULT),
    .RESULT_VALID  (RESULT_VALID),
    .OVERFLOW      (OVERFLOW),
    .VDD           (VDD),
    .VSS           (VSS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Beat patterns: 0 none, 1 constant, 2 odd cycles, 3 both window boundaries.
  function automatic logic beat_of(input int pat, input int i, input int weff);
    case (pat)
      1:       return 1'b1;
      2:       return i[0];
      3:       return (i == S) || (i == S + 1) || (i == S + weff) || (i == S + weff + 1);
      default: return 1'b0;
    endcase
  endfunction

  // Cycle i (1-based) is the i-th cycle after the edge that accepts MEAS_REQ.
  task automatic meas(input int win, input int pat, input int exp_res, input int exp_ovf,
                      input bit spurious);
    int   weff;
    exp_t e;
    weff  = (win == 0) ? 1 : win;
    e.res = exp_res[CNT_W-1:0];
    e.ovf = exp_ovf[0];
    sb_q.push_back(e);
    MEAS_REQ      = 1'b1;
    WINDOW_CYCLES = win[WIN_W-1:0];
    step();
    for (int i = 1; i <= S + weff + 1; i++) begin
      BEAT_IN  = beat_of(pat, i, weff);
      MEAS_REQ = spurious && ((i == 2) || (i == S + 2));
      chk("stress_active", MEAS_STRESS, 1);
      chk("busy_active", BUSY, 1);
      chk("meas_done_run", MEAS_DONE, (i == S + weff + 1) ? 1 : 0);
      step();
    end
    MEAS_REQ = 1'b0;
    BEAT_IN  = 1'b0;
    chk("busy_after", BUSY, 0);
    chk("stress_after", MEAS_STRESS, 0);
    chk("meas_done_after", MEAS_DONE, 1);
    chk("result_held", RESULT, exp_res);
    chk("overflow_held", OVERFLOW, exp_ovf);
  endtask

  task automatic abort_run(input int win, input int at_i, input int prev_res);
    MEAS_REQ      = 1'b1;
    WINDOW_CYCLES = win[WIN_W-1:0];
    step();
    MEAS_REQ = 1'b0;
    for (int i = 1; i < at_i; i++) begin
      BEAT_IN = i[0];
      if (i == 1) chk("abort_done_cleared", MEAS_DONE, 0);
      step();
    end
    ABORT   = 1'b1;
    BEAT_IN = 1'b1;
    step();
    ABORT   = 1'b0;
    BEAT_IN = 1'b0;
    chk("abort_busy", BUSY, 0);
    chk("abort_stress", MEAS_STRESS, 0);
    chk("abort_result", RESULT, prev_res);
    chk("abort_meas_done", MEAS_DONE, 0);
    chk("abort_valid", RESULT_VALID, 0);
    step();
    chk("abort_idle", BUSY, 0);
  endtask

  task automatic reset_mid(input int win, input int at_i);
    MEAS_REQ      = 1'b1;
    WINDOW_CYCLES = win[WIN_W-1:0];
    step();
    MEAS_REQ = 1'b0;
    for (int i = 1; i < at_i; i++) begin
      BEAT_IN = 1'b1;
      step();
    end
    RESET = 1'b1;
    step();
    RESET   = 1'b0;
    BEAT_IN = 1'b0;
    chk("rst_stress", MEAS_STRESS, 0);
    chk("rst_done", MEAS_DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_valid", RESULT_VALID, 0);
    chk("rst_overflow", OVERFLOW, 0);
  endtask

  always @(negedge CLK) begin
    if (!RESET && RESULT_VALID) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", RESULT_VALID, 0);
      end else begin
        m_e = sb_q.pop_front();
        chk("sb_result", RESULT, m_e.res);
        chk("sb_overflow", OVERFLOW, m_e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET         = 1'b1;
    MEAS_REQ      = 1'b0;
    ABORT         = 1'b0;
    BEAT_IN       = 1'b0;
    WINDOW_CYCLES = '0;
    repeat (3) step();
    chk("init_stress", MEAS_STRESS, 0);
    chk("init_done", MEAS_DONE, 0);
    chk("init_busy", BUSY, 0);
    chk("init_result", RESULT, 0);
    chk("init_valid", RESULT_VALID, 0);
    chk("init_overflow", OVERFLOW, 0);
    RESET = 1'b0;
    step();
    chk("idle_busy", BUSY, 0);

    meas(10, 2, 5, 0, 1'b0);   // alternate beats over a 10-cycle window
    meas(20, 1, 15, 1, 1'b0);  // saturation with 4-bit counter
    meas(5, 0, 0, 0, 1'b0);    // no beats clears previous overflow
    meas(0, 1, 1, 0, 1'b0);    // zero window acts as one cycle
    meas(3, 3, 2, 0, 1'b0);    // beats only counted inside the window
    meas(10, 2, 5, 0, 1'b0);
    abort_run(10, S + 3, 5);   // abort mid-window
    abort_run(3, S + 3, 5);    // abort on the final window cycle

    MEAS_REQ = 1'b1;
    ABORT    = 1'b1;
    step();
    MEAS_REQ = 1'b0;
    ABORT    = 1'b0;
    chk("req_abort_busy", BUSY, 0);
    chk("req_abort_stress", MEAS_STRESS, 0);
    step();

    meas(4, 2, 2, 0, 1'b1);    // extra requests while busy are dropped
    reset_mid(10, S + 2);
    meas(2, 1, 2, 0, 1'b0);

    repeat (3) step();
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
